// File: rtl/led_mmio_port.sv
// Memory-mapped LED output stage: CPU stores to LED_ADDR are queued in a small
// FIFO and each byte is shown on Led for at least HOLD_CYCLES cycles.
module led_mmio_port #(
  parameter logic [31:0] LED_ADDR    = 32'h0000002C,
  parameter logic [31:0] STAT_ADDR   = 32'h00000030,
  parameter int          DEPTH       = 4,
  parameter int          HOLD_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] RdData,
  output logic        Hit,
  output logic [7:0]  Led
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_hold;
  logic [CW-1:0] w_hold_next;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          r_overflow;
  logic [7:0]    r_led;

  logic w_led_sel;
  logic w_stat_sel;
  logic w_led_wr;
  logic w_stat_wr;
  logic w_empty;
  logic w_full;
  logic w_busy;
  logic w_pop;
  logic w_push;
  logic w_ovf_set;
  logic [3:0] w_count4;
  logic w_unused;

  assign w_led_sel  = (Addr == LED_ADDR);
  assign w_stat_sel = (Addr == STAT_ADDR);
  assign w_led_wr   = MemWrite && w_led_sel;
  assign w_stat_wr  = MemWrite && w_stat_sel;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_COUNT);
  assign w_busy     = (r_state == ST_SHOW);
  assign w_count4   = 4'(r_count);
  assign w_unused   = ^WrData[31:8];

  // Pop decision only looks at the pre-edge count, so a store into an empty
  // FIFO is never bypassed straight onto Led.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_hold_next  = HOLD_LOAD;
          w_state_next = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (r_hold != '0) begin
          w_hold_next = r_hold - 1'b1;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_hold_next = HOLD_LOAD;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A full FIFO still accepts a store when the head leaves on the same edge.
  assign w_push    = w_led_wr && (!w_full || w_pop);
  assign w_ovf_set = w_led_wr && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst && w_push) begin
      r_mem[r_wr_ptr] <= WrData[7:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_led      <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      r_count <= w_count_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_led    <= r_mem[r_rd_ptr];
      end
      // Clearing wins over an overflow raised on the same edge.
      if (w_stat_wr) begin
        r_overflow <= 1'b0;
      end else if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    RdData = 32'h0;
    if (w_led_sel) begin
      RdData = {24'h0, r_led};
    end else if (w_stat_sel) begin
      RdData = {24'h0, r_overflow, w_busy, w_full, w_empty, w_count4};
    end
  end

  assign Hit = (w_led_sel || w_stat_sel) && (MemRead || MemWrite);
  assign Led = r_led;

endmodule
